csr_request_unit: RTL and testbench
===================================

Name: csr_request_unit

Overview:
- Initiator side of the CSR access interface.
- Accepts one CSR micro-op from the integer issue path and decodes CSRRW/RS/RC and their immediate forms.
- Issues a single-cycle request to the CSR file, waits for its registered done/excp/data response, then emits one writeback/exception record toward the ROB.
- Holds at most one CSR op in flight; flush-safe, so a request already issued to the CSR file is always drained.

Parameters:
TAG_W, 6, width of destination physical register tag
ROB_W, 5, width of ROB entry id
TIMEOUT_CYCLES, 16, WAIT-state cycles before watchdog fires (only with CSR_TIMEOUT_EN)

Ports:
cpu_clock_i  in  1  core clock
cpu_reset_n_i  in  1  reset; synchronous, active-low
uop_valid_i  in  1  CSR micro-op offered
uop_ready_o  out  1  unit can accept (IDLE only)
uop_funct3_i  in  3  instruction funct3
uop_csr_addr_i  in  12  CSR address
uop_rs1_data_i  in  32  rs1 value
uop_rs1_idx_i  in  5  rs1 index / zimm
uop_instr_i  in  32  raw instruction, used for mtval
uop_dest_i  in  TAG_W  destination tag
uop_rob_id_i  in  ROB_W  ROB id
flush_i  in  1  pipeline flush
csrfile_valid_o  out  1  request strobe
csrfile_address_o  out  12  CSR address
csrfile_opcode_o  out  2  01 RW, 10 RS, 11 RC
csrfile_wr_en_o  out  1  request has write side effect
csrfile_data_o  out  32  write operand
csrfile_done_i  in  1  response strobe
csrfile_excp_i  in  1  access illegal
csrfile_data_i  in  32  old CSR value
wb_valid_o  out  1  result/exception record valid (one cycle)
wb_dest_o  out  TAG_W  latched dest
wb_rob_id_o  out  ROB_W  latched ROB id
wb_data_o  out  32  old CSR value
wb_excp_o  out  1  record is an exception
wb_mcause_o  out  4  2 (illegal instruction) when wb_excp_o
wb_mtval_o  out  32  latched instruction when wb_excp_o, else 0
busy_o  out  1  state != IDLE

Behaviour:
- Reset (cpu_reset_n_i=0 at posedge):
  - state=IDLE.
  - All csrfile_* outputs and all wb_* outputs = 0.
  - Watchdog counter = 0.
  - Reset dominates flush and every other input, in any state.
- States: IDLE, REQ, WAIT, DRAIN, RESP.
- IDLE:
  - uop_ready_o=1.
  - Accept on uop_valid_i & !flush_i: latch all uop fields.
  - Decode on accept:
    - opcode = funct3[1:0].
    - operand = funct3[2] ? {27'b0, rs1_idx} : rs1_data.
    - wr_en = (funct3[1:0]==01) | (rs1_idx!=0).
  - If funct3[1:0]==00: illegal; go to RESP with excp=1 and no CSR request issued. Otherwise go to REQ.
  - csrfile_done_i seen in IDLE is ignored.
- REQ:
  - csrfile_valid_o=1 for exactly this cycle; address/opcode/wr_en/data held stable from latches.
  - If flush_i: suppress csrfile_valid_o (drive 0), go to IDLE, no writeback.
  - Else go to WAIT.
- WAIT:
  - On csrfile_done_i: latch data_i and excp_i, go to RESP.
  - On flush_i without done: go to DRAIN.
  - On flush_i with done in the same cycle: discard the response, go to IDLE.
- DRAIN:
  - Wait for csrfile_done_i, discard the response, go to IDLE.
  - flush_i has no further effect.
- RESP:
  - wb_valid_o=1 for one cycle. wb_excp_o = latched excp.
  - If excp: wb_mcause_o=2, wb_mtval_o=latched instr, wb_data_o=0.
  - If no excp: wb_data_o = latched CSR data, mcause and mtval = 0.
  - flush_i in RESP suppresses wb_valid_o.
  - Always go to IDLE next cycle.
- Latency:
  - Accept at cycle N, csrfile_valid_o at N+1, done expected at N+2, wb_valid_o at N+3.
  - Illegal funct3: wb_valid_o at N+1.
  - Back-to-back accept: earliest at cycle N+4.
- csrfile_* outputs are registered; csrfile_valid_o is never high outside REQ.

Optional Feature:
- Macro CSR_TIMEOUT_EN.
- With it defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT and DRAIN, cleared on entry.
  - WAIT reaching TIMEOUT_CYCLES without done: go to RESP with excp=1, mcause=2, mtval=instr.
  - DRAIN reaching TIMEOUT_CYCLES: go to IDLE silently.
  - A late done is then ignored in IDLE.
- Without it: no counter; WAIT and DRAIN wait indefinitely.

Test Plan:
- CSRRS funct3=010, rs1_idx=0, addr 0x340, csrfile returns data 0xDEADBEEF excp=0 → csrfile_valid_o one cycle with wr_en=0, opcode=10; wb_valid_o 3 cycles after accept with wb_data_o=0xDEADBEEF, wb_excp_o=0.
- CSRRWI funct3=101, rs1_idx=0x1F, addr 0x305 → csrfile_data_o=0x0000001F, wr_en=1, opcode=01.
- funct3=000, instr=0x00001073 → no csrfile_valid_o; wb_valid_o next cycle with wb_excp_o=1, wb_mcause_o=2, wb_mtval_o=0x00001073.
- Response with csrfile_excp_i=1 → wb_excp_o=1, wb_mcause_o=2, wb_data_o=0.
- flush_i in REQ → csrfile_valid_o stays 0, no wb_valid_o. flush_i in WAIT, done 1 cycle later → no wb_valid_o, uop_ready_o returns the cycle after done.
- CSR_TIMEOUT_EN, TIMEOUT_CYCLES=16, csrfile never responds → wb_valid_o with wb_excp_o=1 after 16 WAIT cycles. cpu_reset_n_i low mid-WAIT → IDLE with all outputs 0 on the next cycle.

Source files
------------

// File: rtl/csr_request_unit.sv
// CSR request unit: takes one CSR micro-op, issues it to the CSR file and returns a ROB writeback record.
// Optional watchdog on the CSR file response is enabled by defining CSR_TIMEOUT_EN.
module csr_request_unit #(
    parameter int TAG_W          = 6,
    parameter int ROB_W          = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_n_i,
    input  logic             uop_valid_i,
    output logic             uop_ready_o,
    input  logic [2:0]       uop_funct3_i,
    input  logic [11:0]      uop_csr_addr_i,
    input  logic [31:0]      uop_rs1_data_i,
    input  logic [4:0]       uop_rs1_idx_i,
    input  logic [31:0]      uop_instr_i,
    input  logic [TAG_W-1:0] uop_dest_i,
    input  logic [ROB_W-1:0] uop_rob_id_i,
    input  logic             flush_i,
    output logic             csrfile_valid_o,
    output logic [11:0]      csrfile_address_o,
    output logic [1:0]       csrfile_opcode_o,
    output logic             csrfile_wr_en_o,
    output logic [31:0]      csrfile_data_o,
    input  logic             csrfile_done_i,
    input  logic             csrfile_excp_i,
    input  logic [31:0]      csrfile_data_i,
    output logic             wb_valid_o,
    output logic [TAG_W-1:0] wb_dest_o,
    output logic [ROB_W-1:0] wb_rob_id_o,
    output logic [31:0]      wb_data_o,
    output logic             wb_excp_o,
    output logic [3:0]       wb_mcause_o,
    output logic [31:0]      wb_mtval_o,
    output logic             busy_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [3:0] MCAUSE_ILLEGAL = 4'd2;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]       state_q, state_d;
    logic [11:0]      addr_q, addr_d;
    logic [1:0]       op_q, op_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             csr_valid_q, csr_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [TAG_W-1:0] dest_q, dest_d;
    logic [ROB_W-1:0] rob_q, rob_d;

    logic             wb_valid_q, wb_valid_d;
    logic             wb_excp_q, wb_excp_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [3:0]       wb_mcause_q, wb_mcause_d;
    logic [31:0]      wb_mtval_q, wb_mtval_d;
    logic [TAG_W-1:0] wb_dest_q, wb_dest_d;
    logic [ROB_W-1:0] wb_rob_q, wb_rob_d;

    logic             accept;
    logic             resp_excp;
    logic [31:0]      resp_data;
    logic             wdog_expired;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        resp_excp = 1'b0;
        resp_data = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (uop_valid_i && !flush_i) begin
                    accept = 1'b1;
                    if (uop_funct3_i[1:0] == 2'b00) begin
                        state_d   = ST_RESP;
                        resp_excp = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: state_d = flush_i ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (csrfile_done_i) begin
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_RESP;
                        resp_excp = csrfile_excp_i;
                        resp_data = csrfile_data_i;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end else if (wdog_expired) begin
                    state_d   = ST_RESP;
                    resp_excp = 1'b1;
                end
            end
            // An issued request must see its response before the next op may start.
            ST_DRAIN: begin
                if (csrfile_done_i || wdog_expired) state_d = ST_IDLE;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        op_d    = op_q;
        wr_en_d = wr_en_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        dest_d  = dest_q;
        rob_d   = rob_q;
        if (accept) begin
            addr_d  = uop_csr_addr_i;
            op_d    = uop_funct3_i[1:0];
            // Set/clear with a zero source register must not cause CSR write side effects.
            wr_en_d = (uop_funct3_i[1:0] == 2'b01) || (uop_rs1_idx_i != 5'd0);
            wdata_d = uop_funct3_i[2] ? {27'b0, uop_rs1_idx_i} : uop_rs1_data_i;
            instr_d = uop_instr_i;
            dest_d  = uop_dest_i;
            rob_d   = uop_rob_id_i;
        end
    end

    assign csr_valid_d = (state_d == ST_REQ);

    always_comb begin
        wb_valid_d  = 1'b0;
        wb_excp_d   = 1'b0;
        wb_data_d   = 32'h0;
        wb_mcause_d = 4'd0;
        wb_mtval_d  = 32'h0;
        wb_dest_d   = '0;
        wb_rob_d    = '0;
        if (state_d == ST_RESP) begin
            wb_valid_d = 1'b1;
            wb_excp_d  = resp_excp;
            wb_dest_d  = dest_d;
            wb_rob_d   = rob_d;
            if (resp_excp) begin
                wb_mcause_d = MCAUSE_ILLEGAL;
                wb_mtval_d  = instr_d;
            end else begin
                wb_data_d = resp_data;
            end
        end
    end

`ifdef CSR_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Counts consecutive cycles spent in WAIT or DRAIN; any state change restarts it.
    always_comb begin
        wdog_d = '0;
        if ((state_q == ST_WAIT || state_q == ST_DRAIN) && state_d == state_q) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_n_i) wdog_q <= '0;
        else                wdog_q <= wdog_d;
    end
`else
    assign wdog_expired = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_n_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= 12'h0;
            op_q        <= 2'b00;
            wr_en_q     <= 1'b0;
            wdata_q     <= 32'h0;
            csr_valid_q <= 1'b0;
            instr_q     <= 32'h0;
            dest_q      <= '0;
            rob_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_excp_q   <= 1'b0;
            wb_data_q   <= 32'h0;
            wb_mcause_q <= 4'd0;
            wb_mtval_q  <= 32'h0;
            wb_dest_q   <= '0;
            wb_rob_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            wr_en_q     <= wr_en_d;
            wdata_q     <= wdata_d;
            csr_valid_q <= csr_valid_d;
            instr_q     <= instr_d;
            dest_q      <= dest_d;
            rob_q       <= rob_d;
            wb_valid_q  <= wb_valid_d;
            wb_excp_q   <= wb_excp_d;
            wb_data_q   <= wb_data_d;
            wb_mcause_q <= wb_mcause_d;
            wb_mtval_q  <= wb_mtval_d;
            wb_dest_q   <= wb_dest_d;
            wb_rob_q    <= wb_rob_d;
        end
    end

    // A flush in the same cycle cancels the strobe while the payload stays registered.
    assign csrfile_valid_o   = csr_valid_q & ~flush_i;
    assign csrfile_address_o = addr_q;
    assign csrfile_opcode_o  = op_q;
    assign csrfile_wr_en_o   = wr_en_q;
    assign csrfile_data_o    = wdata_q;

    assign wb_valid_o  = wb_valid_q & ~flush_i;
    assign wb_excp_o   = wb_excp_q;
    assign wb_data_o   = wb_data_q;
    assign wb_mcause_o = wb_mcause_q;
    assign wb_mtval_o  = wb_mtval_q;
    assign wb_dest_o   = wb_dest_q;
    assign wb_rob_id_o = wb_rob_q;

    assign uop_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csr_request_unit.sv
// Self-checking bench for csr_request_unit: directed vector table, hand sequences and a randomized
// run against a timeline model of one transaction. Timeout cases run only when CSR_TIMEOUT_EN is defined.
module tb_csr_request_unit;

    localparam int TAG_W = 6;
    localparam int ROB_W = 5;
    localparam int TMO   = 16;

    logic             cpu_clock_i;
    logic             cpu_reset_n_i;
    logic             uop_valid_i;
    logic             uop_ready_o;
    logic [2:0]       uop_funct3_i;
    logic [11:0]      uop_csr_addr_i;
    logic [31:0]      uop_rs1_data_i;
    logic [4:0]       uop_rs1_idx_i;
    logic [31:0]      uop_instr_i;
    logic [TAG_W-1:0] uop_dest_i;
    logic [ROB_W-1:0] uop_rob_id_i;
    logic             flush_i;
    logic             csrfile_valid_o;
    logic [11:0]      csrfile_address_o;
    logic [1:0]       csrfile_opcode_o;
    logic             csrfile_wr_en_o;
    logic [31:0]      csrfile_data_o;
    logic             csrfile_done_i;
    logic             csrfile_excp_i;
    logic [31:0]      csrfile_data_i;
    logic             wb_valid_o;
    logic [TAG_W-1:0] wb_dest_o;
    logic [ROB_W-1:0] wb_rob_id_o;
    logic [31:0]      wb_data_o;
    logic             wb_excp_o;
    logic [3:0]       wb_mcause_o;
    logic [31:0]      wb_mtval_o;
    logic             busy_o;

    csr_request_unit #(.TAG_W(TAG_W), .ROB_W(ROB_W), .TIMEOUT_CYCLES(TMO)) dut (
        .cpu_clock_i(cpu_clock_i), .cpu_reset_n_i(cpu_reset_n_i),
        .uop_valid_i(uop_valid_i), .uop_ready_o(uop_ready_o),
        .uop_funct3_i(uop_funct3_i), .uop_csr_addr_i(uop_csr_addr_i),
        .uop_rs1_data_i(uop_rs1_data_i), .uop_rs1_idx_i(uop_rs1_idx_i),
        .uop_instr_i(uop_instr_i), .uop_dest_i(uop_dest_i), .uop_rob_id_i(uop_rob_id_i),
        .flush_i(flush_i),
        .csrfile_valid_o(csrfile_valid_o), .csrfile_address_o(csrfile_address_o),
        .csrfile_opcode_o(csrfile_opcode_o), .csrfile_wr_en_o(csrfile_wr_en_o),
        .csrfile_data_o(csrfile_data_o), .csrfile_done_i(csrfile_done_i),
        .csrfile_excp_i(csrfile_excp_i), .csrfile_data_i(csrfile_data_i),
        .wb_valid_o(wb_valid_o), .wb_dest_o(wb_dest_o), .wb_rob_id_o(wb_rob_id_o),
        .wb_data_o(wb_data_o), .wb_excp_o(wb_excp_o), .wb_mcause_o(wb_mcause_o),
        .wb_mtval_o(wb_mtval_o), .busy_o(busy_o)
    );

    // One transaction: stimulus, CSR-file behaviour, and the expected observable timeline.
    // Offsets count cycles from the accept cycle (offset 0).
    typedef struct {
        logic [2:0]       funct3;
        logic [11:0]      addr;
        logic [31:0]      rs1_data;
        logic [4:0]       rs1_idx;
        logic [31:0]      instr;
        logic [TAG_W-1:0] dest;
        logic [ROB_W-1:0] rob;
        logic             rsp_excp;
        logic [31:0]      rsp_data;
        int               delay;      // extra cycles after the first WAIT cycle before done
        int               flush_at;   // offset of a one-cycle flush, 0 = none
        bit               no_resp;    // CSR file never answers
        int               exp_req_n;
        logic [1:0]       exp_op;
        logic             exp_wr;
        logic [31:0]      exp_wdata;
        int               exp_wb_t;   // offset of the writeback pulse, -1 = none
        logic             exp_excp;
        logic [31:0]      exp_data;
        logic [3:0]       exp_mcause;
        logic [31:0]      exp_mtval;
        int               exp_idle_t; // first offset at which the unit is ready again
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    initial cpu_clock_i = 1'b0;
    always #5 cpu_clock_i = ~cpu_clock_i;

    initial begin
        #2_000_000;
        $display("FAIL global time limit: run did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clock_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " csr_valid"}, 32'(csrfile_valid_o), 32'h0);
        check({tag, " csr_addr"},  32'(csrfile_address_o), 32'h0);
        check({tag, " csr_op"},    32'(csrfile_opcode_o), 32'h0);
        check({tag, " csr_wr"},    32'(csrfile_wr_en_o), 32'h0);
        check({tag, " csr_data"},  csrfile_data_o, 32'h0);
        check({tag, " wb_valid"},  32'(wb_valid_o), 32'h0);
        check({tag, " wb_data"},   wb_data_o, 32'h0);
        check({tag, " wb_excp"},   32'(wb_excp_o), 32'h0);
        check({tag, " wb_mcause"}, 32'(wb_mcause_o), 32'h0);
        check({tag, " wb_mtval"},  wb_mtval_o, 32'h0);
        check({tag, " wb_dest"},   32'(wb_dest_o), 32'h0);
        check({tag, " wb_rob"},    32'(wb_rob_id_o), 32'h0);
        check({tag, " ready"},     32'(uop_ready_o), 32'h1);
        check({tag, " busy"},      32'(busy_o), 32'h0);
    endtask

    // Expected outcome from the interface rules: what the CSR file sees, whether and when the ROB
    // gets a record, and when the unit is free again.
    function automatic vec_t model(input vec_t s);
        vec_t e = s;
        int   done_t = 2 + s.delay;
        bit   legal  = (s.funct3[1:0] != 2'b00);
        e.exp_op    = s.funct3[1:0];
        e.exp_wr    = (s.funct3[1:0] == 2'b01) || (s.rs1_idx != 5'd0);
        e.exp_wdata = s.funct3[2] ? 32'(s.rs1_idx) : s.rs1_data;
        e.exp_excp  = legal ? s.rsp_excp : 1'b1;
        if (!legal) begin
            e.exp_req_n  = 0;
            e.exp_wb_t   = (s.flush_at == 1) ? -1 : 1;
            e.exp_idle_t = 2;
        end else if (s.flush_at == 1) begin
            e.exp_req_n  = 0;
            e.exp_wb_t   = -1;
            e.exp_idle_t = 2;
        end else begin
            e.exp_req_n = 1;
            if (s.flush_at >= 2 && s.flush_at <= done_t) begin
                e.exp_wb_t   = -1;
                e.exp_idle_t = done_t + 1;
            end else begin
                e.exp_wb_t   = (s.flush_at == done_t + 1) ? -1 : done_t + 1;
                e.exp_idle_t = done_t + 2;
            end
        end
        e.exp_data   = e.exp_excp ? 32'h0 : s.rsp_data;
        e.exp_mcause = e.exp_excp ? 4'd2 : 4'd0;
        e.exp_mtval  = e.exp_excp ? s.instr : 32'h0;
        return e;
    endfunction

    // Drives one micro-op, acts as the CSR file, and compares the whole observed timeline.
    task automatic run_vec(input vec_t v, input string tag);
        int          req_n = 0;
        int          req_t = -1;
        int          wb_n  = 0;
        int          wb_t  = -1;
        int          last_t;
        logic [11:0] c_addr = '0;
        logic [1:0]  c_op = '0;
        logic        c_wr = 1'b0;
        logic [31:0] c_wdata = '0;
        logic        c_excp = 1'b0;
        logic [31:0] c_data = '0;
        logic [3:0]  c_mcause = '0;
        logic [31:0] c_mtval = '0;
        logic [TAG_W-1:0] c_dest = '0;
        logic [ROB_W-1:0] c_rob = '0;
        last_t = ((v.exp_idle_t > v.exp_wb_t) ? v.exp_idle_t : v.exp_wb_t) + 2;
        uop_funct3_i   = v.funct3;
        uop_csr_addr_i = v.addr;
        uop_rs1_data_i = v.rs1_data;
        uop_rs1_idx_i  = v.rs1_idx;
        uop_instr_i    = v.instr;
        uop_dest_i     = v.dest;
        uop_rob_id_i   = v.rob;
        for (int t = 0; t <= last_t; t++) begin
            uop_valid_i    = (t == 0);
            flush_i        = (v.flush_at != 0) && (t == v.flush_at);
            csrfile_done_i = (req_t >= 0) && !v.no_resp && (t == req_t + 1 + v.delay);
            csrfile_excp_i = csrfile_done_i ? v.rsp_excp : 1'($urandom);
            csrfile_data_i = csrfile_done_i ? v.rsp_data : $urandom;
            #1;
            check($sformatf("%s ready@%0d", tag, t), 32'(uop_ready_o),
                  32'((t == 0) || (t >= v.exp_idle_t)));
            check($sformatf("%s busy@%0d", tag, t), 32'(busy_o),
                  32'(!((t == 0) || (t >= v.exp_idle_t))));
            if (csrfile_valid_o) begin
                req_n++;
                req_t   = t;
                c_addr  = csrfile_address_o;
                c_op    = csrfile_opcode_o;
                c_wr    = csrfile_wr_en_o;
                c_wdata = csrfile_data_o;
            end
            if (wb_valid_o) begin
                wb_n++;
                wb_t     = t;
                c_excp   = wb_excp_o;
                c_data   = wb_data_o;
                c_mcause = wb_mcause_o;
                c_mtval  = wb_mtval_o;
                c_dest   = wb_dest_o;
                c_rob    = wb_rob_id_o;
            end
            step();
        end
        uop_valid_i    = 1'b0;
        flush_i        = 1'b0;
        csrfile_done_i = 1'b0;
        check({tag, " req_count"}, 32'(req_n), 32'(v.exp_req_n));
        if (v.exp_req_n == 1) begin
            check({tag, " req_time"}, 32'(req_t), 32'd1);
            check({tag, " req_addr"}, 32'(c_addr), 32'(v.addr));
            check({tag, " req_op"},   32'(c_op), 32'(v.exp_op));
            check({tag, " req_wr"},   32'(c_wr), 32'(v.exp_wr));
            check({tag, " req_data"}, c_wdata, v.exp_wdata);
        end
        check({tag, " wb_count"}, 32'(wb_n), (v.exp_wb_t >= 0) ? 32'd1 : 32'd0);
        check({tag, " wb_time"},  32'(wb_t), 32'(v.exp_wb_t));
        if (v.exp_wb_t >= 0) begin
            check({tag, " wb_excp"},   32'(c_excp), 32'(v.exp_excp));
            check({tag, " wb_data"},   c_data, v.exp_data);
            check({tag, " wb_mcause"}, 32'(c_mcause), 32'(v.exp_mcause));
            check({tag, " wb_mtval"},  c_mtval, v.exp_mtval);
            check({tag, " wb_dest"},   32'(c_dest), 32'(v.dest));
            check({tag, " wb_rob"},    32'(c_rob), 32'(v.rob));
        end
    endtask

    vec_t dir_tab[12];

    initial begin
        vec_t s;
        // funct3 addr rs1_data idx instr dest rob | rexcp rdata delay flush nores |
        // req op wr wdata wb_t excp data mcause mtval idle
        dir_tab[0]  = '{3'b010, 12'h340, 32'h1234_5678, 5'd0,  32'h3400_2573, 6'd9,  5'd3,  1'b0, 32'hDEAD_BEEF, 0, 0, 1'b0,
                        1, 2'b10, 1'b0, 32'h1234_5678, 3, 1'b0, 32'hDEAD_BEEF, 4'd0, 32'h0, 4};
        dir_tab[1]  = '{3'b101, 12'h305, 32'hAAAA_5555, 5'h1F, 32'h305F_D073, 6'd17, 5'd4,  1'b0, 32'h0000_0800, 0, 0, 1'b0,
                        1, 2'b01, 1'b1, 32'h0000_001F, 3, 1'b0, 32'h0000_0800, 4'd0, 32'h0, 4};
        dir_tab[2]  = '{3'b000, 12'h000, 32'h0000_0000, 5'd0,  32'h0000_1073, 6'd1,  5'd5,  1'b0, 32'h0000_0000, 0, 0, 1'b0,
                        0, 2'b00, 1'b0, 32'h0, 1, 1'b1, 32'h0, 4'd2, 32'h0000_1073, 2};
        dir_tab[3]  = '{3'b011, 12'h7C0, 32'h0F0F_0000, 5'd3,  32'h7C01_B073, 6'd33, 5'd6,  1'b1, 32'h0000_0055, 0, 0, 1'b0,
                        1, 2'b11, 1'b1, 32'h0F0F_0000, 3, 1'b1, 32'h0, 4'd2, 32'h7C01_B073, 4};
        dir_tab[4]  = '{3'b110, 12'h300, 32'hFFFF_FFFF, 5'd0,  32'h3000_6073, 6'd40, 5'd7,  1'b0, 32'h0000_1888, 2, 0, 1'b0,
                        1, 2'b10, 1'b0, 32'h0, 5, 1'b0, 32'h0000_1888, 4'd0, 32'h0, 6};
        dir_tab[5]  = '{3'b100, 12'h123, 32'h0000_0005, 5'd5,  32'h1232_C073, 6'd2,  5'd8,  1'b0, 32'h0000_0000, 0, 0, 1'b0,
                        0, 2'b00, 1'b0, 32'h0, 1, 1'b1, 32'h0, 4'd2, 32'h1232_C073, 2};
        dir_tab[6]  = '{3'b001, 12'h341, 32'h8000_0004, 5'd0,  32'h3410_1073, 6'd63, 5'd31, 1'b0, 32'h8000_0000, 0, 0, 1'b0,
                        1, 2'b01, 1'b1, 32'h8000_0004, 3, 1'b0, 32'h8000_0000, 4'd0, 32'h0, 4};
        dir_tab[7]  = '{3'b001, 12'h341, 32'h0000_0001, 5'd1,  32'h0000_0001, 6'd5,  5'd9,  1'b0, 32'h0000_0077, 0, 1, 1'b0,
                        0, 2'b00, 1'b0, 32'h0, -1, 1'b0, 32'h0, 4'd0, 32'h0, 2};
        dir_tab[8]  = '{3'b010, 12'hF14, 32'h0000_0000, 5'd2,  32'h0000_0002, 6'd6,  5'd10, 1'b0, 32'h0000_0099, 1, 2, 1'b0,
                        1, 2'b10, 1'b1, 32'h0, -1, 1'b0, 32'h0, 4'd0, 32'h0, 4};
        dir_tab[9]  = '{3'b011, 12'h344, 32'h0000_00FF, 5'd0,  32'h0000_0003, 6'd7,  5'd11, 1'b0, 32'h0000_0044, 0, 2, 1'b0,
                        1, 2'b11, 1'b0, 32'h0000_00FF, -1, 1'b0, 32'h0, 4'd0, 32'h0, 3};
        dir_tab[10] = '{3'b001, 12'h340, 32'hCAFE_F00D, 5'd8,  32'h0000_0004, 6'd8,  5'd12, 1'b0, 32'h0000_0011, 0, 3, 1'b0,
                        1, 2'b01, 1'b1, 32'hCAFE_F00D, -1, 1'b0, 32'h0, 4'd0, 32'h0, 4};
        dir_tab[11] = '{3'b000, 12'h001, 32'h0000_0000, 5'd0,  32'h0000_0005, 6'd9,  5'd13, 1'b0, 32'h0000_0000, 0, 1, 1'b0,
                        0, 2'b00, 1'b0, 32'h0, -1, 1'b0, 32'h0, 4'd0, 32'h0, 2};

        cpu_reset_n_i  = 1'b0;
        uop_valid_i    = 1'b0;
        uop_funct3_i   = 3'b0;
        uop_csr_addr_i = 12'h0;
        uop_rs1_data_i = 32'h0;
        uop_rs1_idx_i  = 5'd0;
        uop_instr_i    = 32'h0;
        uop_dest_i     = '0;
        uop_rob_id_i   = '0;
        flush_i        = 1'b0;
        csrfile_done_i = 1'b0;
        csrfile_excp_i = 1'b0;
        csrfile_data_i = 32'h0;
        repeat (3) step();
        check_all_zero("reset");
        cpu_reset_n_i = 1'b1;
        step();

        for (int i = 0; i < 12; i++) run_vec(dir_tab[i], $sformatf("dir%0d", i));

        // A stray response while idle must produce nothing.
        for (int t = 0; t < 2; t++) begin
            csrfile_done_i = 1'b1;
            csrfile_excp_i = 1'b1;
            csrfile_data_i = 32'h5A5A_5A5A;
            #1;
            check($sformatf("idle_done wb_valid@%0d", t), 32'(wb_valid_o), 32'h0);
            check($sformatf("idle_done csr_valid@%0d", t), 32'(csrfile_valid_o), 32'h0);
            check($sformatf("idle_done busy@%0d", t), 32'(busy_o), 32'h0);
            step();
        end
        csrfile_done_i = 1'b0;
        csrfile_excp_i = 1'b0;

        // Reset asserted while waiting for the CSR file, then a late response arrives.
        uop_funct3_i   = 3'b001;
        uop_csr_addr_i = 12'h7B0;
        uop_rs1_data_i = 32'h1357_9BDF;
        uop_rs1_idx_i  = 5'd4;
        uop_instr_i    = 32'h7B02_1073;
        uop_dest_i     = 6'd21;
        uop_rob_id_i   = 5'd22;
        uop_valid_i    = 1'b1;
        step();
        uop_valid_i = 1'b0;
        step();
        #1;
        check("rst_wait busy_before", 32'(busy_o), 32'h1);
        cpu_reset_n_i = 1'b0;
        step();
        check_all_zero("rst_wait");
        cpu_reset_n_i  = 1'b1;
        csrfile_done_i = 1'b1;
        csrfile_data_i = 32'h2468_ACE0;
        step();
        csrfile_done_i = 1'b0;
        #1;
        check("rst_wait late_done wb_valid", 32'(wb_valid_o), 32'h0);
        check("rst_wait late_done busy", 32'(busy_o), 32'h0);
        step();

`ifdef CSR_TIMEOUT_EN
        s = '{3'b001, 12'h345, 32'h0000_00AA, 5'd1, 32'h3450_9073, 6'd12, 5'd14, 1'b0, 32'h0, 0, 0, 1'b1,
              1, 2'b01, 1'b1, 32'h0000_00AA, 2 + TMO, 1'b1, 32'h0, 4'd2, 32'h3450_9073, 3 + TMO};
        run_vec(s, "wait_timeout");
        s = '{3'b010, 12'h346, 32'h0000_0000, 5'd0, 32'h3460_2073, 6'd13, 5'd15, 1'b0, 32'h0, 0, 2, 1'b1,
              1, 2'b10, 1'b0, 32'h0, -1, 1'b0, 32'h0, 4'd0, 32'h0, 3 + TMO};
        run_vec(s, "drain_timeout");
`endif

        for (int i = 0; i < 150; i++) begin
            s          = dir_tab[0];
            s.funct3   = 3'($urandom_range(0, 7));
            s.addr     = 12'($urandom);
            s.rs1_data = $urandom;
            s.rs1_idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            s.instr    = $urandom;
            s.dest     = TAG_W'($urandom);
            s.rob      = ROB_W'($urandom);
            s.rsp_excp = ($urandom_range(0, 3) == 0);
            s.rsp_data = $urandom;
            s.delay    = int'($urandom_range(0, 3));
            s.flush_at = int'($urandom_range(0, 9));
            if (s.flush_at > 6) s.flush_at = 0;
            s.no_resp  = 1'b0;
            run_vec(model(s), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
